// File: rtl/gpmc_pkg.sv
// gpmc_pkg: shared GPMC bus states, AD width and parameter range limits
package gpmc_pkg;
  localparam int GPMC_AD_WIDTH = 16;
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 15;
  localparam int TURN_CYCLES_MIN = 1;
  localparam int TURN_CYCLES_MAX = 7;
  typedef enum logic [2:0] {IDLE, ADDR, W_DATA, R_WAIT, TURN} gpmc_state_e;
endpackage

// File: rtl/gpmc_clk_gen.sv
// gpmc_clk_gen: free-running clk/2 bus phase with rise/fall tick strobes
module gpmc_clk_gen (
  input  logic clk,
  input  logic rst,
  output logic phase,
  output logic rise,
  output logic fall
);
  logic phase_q, phase_d;
  assign phase_d = ~phase_q;
  always_ff @(posedge clk) phase_q <= rst ? 1'b0 : phase_d;
  assign phase = phase_q;
  assign rise = ~phase_q;
  assign fall = phase_q;
endmodule

// File: rtl/gpmc_sync_master.sv
// gpmc_sync_master: GPMC sync muxed-AD initiator; GPMC_SYNC_MASTER_WAIT_EN adds the gpmc_wait stall input
module gpmc_sync_master
  import gpmc_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int RD_LATENCY  = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     busy,
  output logic                     gpmc_clk,
  output logic                     gpmc_cs_n,
  output logic                     gpmc_adv_n,
  output logic                     gpmc_we_n,
  output logic                     gpmc_oe_n,
  output logic [GPMC_AD_WIDTH-1:0] gpmc_ad_out,
  output logic                     gpmc_ad_oe,
`ifdef GPMC_SYNC_MASTER_WAIT_EN
  input  logic                     gpmc_wait,
`endif
  input  logic [GPMC_AD_WIDTH-1:0] gpmc_ad_in
);
  localparam logic [3:0] RD_LAST = 4'(RD_LATENCY - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  if (ADDR_WIDTH > GPMC_AD_WIDTH || DATA_WIDTH > GPMC_AD_WIDTH ||
      RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX ||
      TURN_CYCLES < TURN_CYCLES_MIN || TURN_CYCLES > TURN_CYCLES_MAX) begin : g_bad_param
    $error("gpmc_sync_master: parameter out of range");
  end
  logic phase, rise, fall;
  gpmc_clk_gen u_clk_gen (.clk(clk), .rst(rst), .phase(phase), .rise(rise), .fall(fall));
  gpmc_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, write_q, write_d, rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic accept, rd_last, wait_in, wait_q;
`ifdef GPMC_SYNC_MASTER_WAIT_EN
  logic wait_d;
  assign wait_in = gpmc_wait;
  assign wait_d = rise ? gpmc_wait : wait_q;
  always_ff @(posedge clk) wait_q <= rst ? 1'b0 : wait_d;
`else
  assign wait_in = 1'b0;
  assign wait_q = 1'b0;
`endif
  assign req_ready = state_q == IDLE && !busy_q && !rst;
  assign accept = req_valid && req_ready;
  assign rd_last = state_q == R_WAIT && cnt_q >= RD_LAST;
  always_comb begin
    state_d = state_q;
    cnt_d = (fall && cnt_q != 4'hf) ? cnt_q + 4'd1 : cnt_q;
    busy_d = busy_q | accept;
    write_d = accept ? req_write : write_q;
    addr_d = accept ? req_addr : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
    rdata_d = rdata_q;
    rsp_valid_d = 1'b0;
    if (rise && rd_last && !wait_in) begin
      rdata_d = gpmc_ad_in[DATA_WIDTH-1:0];
      rsp_valid_d = 1'b1;
    end
    if (fall) begin
      case (state_q)
        IDLE:    state_d = (busy_q || accept) ? ADDR : IDLE;
        ADDR:    state_d = write_q ? W_DATA : R_WAIT;
        W_DATA:  begin
          state_d = wait_q ? W_DATA : TURN;
          rsp_valid_d = !wait_q;
        end
        R_WAIT:  state_d = (rd_last && !wait_q) ? TURN : R_WAIT;
        default: state_d = state_q;
      endcase
    end
    if (rise && state_q == TURN && cnt_q >= TURN_LAST) begin
      state_d = IDLE;
      busy_d = 1'b0;
    end
    if (state_d != state_q) cnt_d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      busy_q <= 1'b0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
  logic [GPMC_AD_WIDTH-1:0] addr_ext, wdata_ext;
  assign addr_ext = GPMC_AD_WIDTH'(addr_q);
  assign wdata_ext = GPMC_AD_WIDTH'(wdata_q);
  assign gpmc_clk = phase;
  assign gpmc_cs_n = state_q == IDLE || state_q == TURN;
  assign gpmc_adv_n = state_q != ADDR;
  assign gpmc_we_n = !((state_q == ADDR && write_q) || state_q == W_DATA);
  assign gpmc_oe_n = state_q != R_WAIT;
  assign gpmc_ad_oe = state_q == ADDR || state_q == W_DATA;
  assign gpmc_ad_out = state_q == ADDR ? addr_ext : state_q == W_DATA ? wdata_ext : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_gpmc_sync_master.sv
// tb_gpmc_sync_master: directed and random scoreboard bench with a bus responder model
module tb_gpmc_sync_master;
  localparam int RDL = 2;
  localparam int TC = 1;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0, gpmc_ad_in, rsp_rdata, gpmc_ad_out;
  logic req_ready, rsp_valid, busy, gpmc_clk, gpmc_cs_n, gpmc_adv_n, gpmc_we_n, gpmc_oe_n, gpmc_ad_oe;
`ifdef GPMC_SYNC_MASTER_WAIT_EN
  logic gpmc_wait = 1'b0;
`endif
  typedef struct packed {logic w; logic [15:0] a; logic [15:0] d;} req_t;
  req_t exp_q[$];
  logic [16:0] aq[$];
  logic [15:0] wq[$];
  int checks = 0, errors = 0, rsp_count = 0, oe_cycles = 0, gap = 0, last_gap = 0;
  logic [15:0] lat_addr = '0;
  logic [20:0] bus, prev_bus = '0;
  logic prev_g = 1'b1, prev_rst = 1'b1;
  req_t e;
  assign gpmc_ad_in = lat_addr ^ 16'h5AFF;
  always #5 clk = ~clk;
  gpmc_sync_master #(.RD_LATENCY(RDL), .TURN_CYCLES(TC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .gpmc_clk(gpmc_clk), .gpmc_cs_n(gpmc_cs_n), .gpmc_adv_n(gpmc_adv_n),
    .gpmc_we_n(gpmc_we_n), .gpmc_oe_n(gpmc_oe_n), .gpmc_ad_out(gpmc_ad_out), .gpmc_ad_oe(gpmc_ad_oe),
`ifdef GPMC_SYNC_MASTER_WAIT_EN
    .gpmc_wait(gpmc_wait),
`endif
    .gpmc_ad_in(gpmc_ad_in)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    bus = {gpmc_cs_n, gpmc_adv_n, gpmc_we_n, gpmc_oe_n, gpmc_ad_oe, gpmc_ad_out};
    check("oe_overlap", {31'd0, gpmc_ad_oe & ~gpmc_oe_n}, 32'd0);
    if (!prev_g && !prev_rst) check("rise_stable", {11'd0, bus}, {11'd0, prev_bus});
    prev_bus = bus;
    prev_g = gpmc_clk;
    prev_rst = rst;
    if (!gpmc_clk && !rst) begin
      if (!gpmc_cs_n && !gpmc_adv_n) begin
        lat_addr = gpmc_ad_out;
        aq.push_back({gpmc_we_n, gpmc_ad_out});
      end
      if (!gpmc_cs_n && gpmc_adv_n && !gpmc_we_n && gpmc_ad_oe) wq.push_back(gpmc_ad_out);
      if (!gpmc_oe_n) oe_cycles++;
      if (gpmc_cs_n) gap++;
      else if (gap != 0) begin
        last_gap = gap;
        gap = 0;
      end
    end
    if (rsp_valid) begin
      rsp_count++;
      if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        if (aq.size() == 0) check("addr_phase_missing", 32'd0, 32'd1);
        else check("addr_phase", {15'd0, aq.pop_front()}, {15'd0, !e.w, e.a});
        if (e.w) begin
          if (wq.size() == 0) check("wdata_missing", 32'd0, 32'd1);
          else check("wdata", {16'd0, wq.pop_front()}, {16'd0, e.d});
        end else check("rdata", {16'd0, rsp_rdata}, {16'd0, e.a ^ 16'h5AFF});
      end
    end
  end
  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic acc = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      if (busy) check("ready_low_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    if (acc) exp_q.push_back('{w: w, a: a, d: d});
    else check("accept_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      done = !busy && exp_q.size() == 0;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_oe_low();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = !gpmc_oe_n;
    end
    if (!seen) check("oe_timeout", 32'd0, 32'd1);
  endtask
  int rc0;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", {27'd0, gpmc_cs_n, gpmc_adv_n, gpmc_we_n, gpmc_oe_n, gpmc_ad_oe}, 32'h1e);
    check("rst_ad_out", {16'd0, gpmc_ad_out}, 32'd0);
    check("rst_misc", {28'd0, gpmc_clk, req_ready, rsp_valid, busy}, 32'd0);
    check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    rc0 = rsp_count;
    send(1'b1, 16'h1234, 16'hBEEF);
    wait_idle();
    check("wr_rsp_count", rsp_count - rc0, 32'd1);
    oe_cycles = 0;
    rc0 = rsp_count;
    send(1'b0, 16'h00A5, 16'h0);
    wait_idle();
    check("rd_oe_cycles", oe_cycles, RDL);
    check("rd_value", {16'd0, rsp_rdata}, 32'h5A5A);
    check("rd_rsp_count", rsp_count - rc0, 32'd1);
    rc0 = rsp_count;
    send(1'b1, 16'h00C3, 16'h1357);
    send(1'b0, 16'h0F0F, 16'h0);
    wait_idle();
    check("b2b_gap", last_gap, TC);
    check("b2b_rsp_count", rsp_count - rc0, 32'd2);
    check("b2b_rdata", {16'd0, rsp_rdata}, 32'h55F0);
    rc0 = rsp_count;
    send(1'b0, 16'h0042, 16'h0);
    wait_oe_low();
    rst = 1'b1;
    exp_q.delete();
    aq.delete();
    wq.delete();
    @(posedge clk);
    #1;
    check("midrst_bus", {28'd0, gpmc_cs_n, gpmc_oe_n, gpmc_ad_oe, gpmc_clk}, 32'hc);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_rsp", rsp_count - rc0, 32'd0);
    send(1'b0, 16'h0F0F, 16'h0);
    wait_idle();
    check("post_rst_rd", {16'd0, rsp_rdata}, 32'h55F0);
`ifdef GPMC_SYNC_MASTER_WAIT_EN
    oe_cycles = 0;
    rc0 = rsp_count;
    send(1'b0, 16'h3C3C, 16'h0);
    wait_oe_low();
    @(posedge clk);
    #1;
    gpmc_wait = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    gpmc_wait = 1'b0;
    wait_idle();
    check("wait_oe_cycles", oe_cycles, RDL + 3);
    check("wait_rdata", {16'd0, rsp_rdata}, {16'd0, 16'h3C3C ^ 16'h5AFF});
    check("wait_rsp_count", rsp_count - rc0, 32'd1);
`endif
    for (int i = 0; i < 20; i++) begin
      send(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_idle();
    check("sb_empty", exp_q.size() + aq.size() + wq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
